// File: rtl/gnrl_alloc_64x4_ctrl_pkg.sv
// Shared sizes, types and small helpers for the 64-entry, 4-way allocation controller.
package gnrl_alloc_64x4_ctrl_pkg;

   localparam int unsigned ALLOC_ENTRIES = 64;
   localparam int unsigned ALLOC_IDX_W   = 6;
   localparam int unsigned ALLOC_WAYS    = 4;
   localparam int unsigned ALLOC_CNT_W   = 7;

   typedef logic [ALLOC_IDX_W-1:0]   idx_t;
   typedef logic [ALLOC_ENTRIES-1:0] map_t;
   typedef logic [ALLOC_CNT_W-1:0]   cnt_t;

   function automatic map_t onehot64(input idx_t idx);
      map_t oh;
      oh      = '0;
      oh[idx] = 1'b1;
      return oh;
   endfunction

   function automatic logic [2:0] popcnt4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

endpackage

// File: rtl/gnrl_alloc_64x4_ctrl_if.sv
// Request/grant/release bundle between rename/dispatch, commit and the allocation controller.
interface gnrl_alloc_64x4_ctrl_if;
   import gnrl_alloc_64x4_ctrl_pkg::*;

   logic                   alloc_vld;
   logic [2:0]             alloc_cnt;
   logic                   alloc_gnt;
   idx_t [ALLOC_WAYS-1:0]  alloc_idx;
   logic [ALLOC_WAYS-1:0]  rls_vld;
   idx_t [ALLOC_WAYS-1:0]  rls_idx;
   logic                   flush;
   cnt_t                   free_cnt;
   logic                   full_n;
   logic                   err;

   modport master (
      output alloc_vld, alloc_cnt, rls_vld, rls_idx, flush,
      input  alloc_gnt, alloc_idx, free_cnt, full_n, err
   );

   modport slave (
      input  alloc_vld, alloc_cnt, rls_vld, rls_idx, flush,
      output alloc_gnt, alloc_idx, free_cnt, full_n, err
   );

endinterface

// File: rtl/gnrl_pecdr_64sel4_module.sv
// Lowest-first picker: returns the indices of the first four set bits of a 64-bit map.
module gnrl_pecdr_64sel4_module
   import gnrl_alloc_64x4_ctrl_pkg::*;
(
   input  map_t                  free_map_i,
   output idx_t [ALLOC_WAYS-1:0] sel_o
);

   // Unfilled slots stay 0; the controller masks them by free count anyway.
   always_comb begin
      logic [2:0] n;
      sel_o = '0;
      n     = '0;
      for (int i = 0; i < ALLOC_ENTRIES; i++) begin
         if (free_map_i[i] && (n < 3'(ALLOC_WAYS))) begin
            sel_o[n[1:0]] = idx_t'(i);
            n             = n + 3'd1;
         end
      end
   end

endmodule

// File: rtl/gnrl_alloc_64x4_ctrl.sv
// 64-entry allocation controller: free bitmap, 4-way lowest-first grant, 4-way release, flush.
module gnrl_alloc_64x4_ctrl
   import gnrl_alloc_64x4_ctrl_pkg::*;
#(
   parameter map_t        RST_FREE_MAP = 64'hFFFF_FFFF_FFFF_FFFF,
   parameter int unsigned RSV_ENTRIES  = 0
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   gnrl_alloc_64x4_ctrl_if.slave  bus
);

   localparam cnt_t RstFreeCnt = cnt_t'($countones(RST_FREE_MAP));

   map_t                  free_map_q, free_map_d;
   cnt_t                  free_cnt_q, free_cnt_d;
   logic                  err_q, err_d;
   idx_t [ALLOC_WAYS-1:0] sel;
   map_t                  alloc_mask, rls_mask;
   logic [ALLOC_WAYS-1:0] rls_eff;
   logic                  gnt, cnt_legal, dup_rls, dbl_free;
   cnt_t                  alloc_n;

   gnrl_pecdr_64sel4_module u_picker (
      .free_map_i (free_map_q),
      .sel_o      (sel)
   );

   assign cnt_legal = (bus.alloc_cnt <= 3'd4);

   always_comb begin
      gnt = i_rst_n & bus.alloc_vld & ~bus.flush & cnt_legal &
            (32'(free_cnt_q) >= (32'(bus.alloc_cnt) + RSV_ENTRIES));
      alloc_n = gnt ? cnt_t'(bus.alloc_cnt) : '0;
   end

   always_comb begin
      bus.alloc_idx = '0;
      alloc_mask    = '0;
      for (int k = 0; k < ALLOC_WAYS; k++) begin
         if (free_cnt_q > cnt_t'(k)) begin
            bus.alloc_idx[k] = sel[k];
         end
         if (gnt && (3'(k) < bus.alloc_cnt)) begin
            alloc_mask = alloc_mask | onehot64(sel[k]);
         end
      end
   end

   // A slot only adds to the count if it names a bit not free after this cycle's
   // allocation and no earlier slot already named it; this keeps count == popcount(map).
   always_comb begin
      rls_mask = '0;
      rls_eff  = '0;
      dup_rls  = 1'b0;
      for (int k = 0; k < ALLOC_WAYS; k++) begin
         if (bus.rls_vld[k]) begin
            rls_mask   = rls_mask | onehot64(bus.rls_idx[k]);
            rls_eff[k] = ~(free_map_q[bus.rls_idx[k]] & ~alloc_mask[bus.rls_idx[k]]);
            for (int j = 0; j < k; j++) begin
               if (bus.rls_vld[j] && (bus.rls_idx[j] == bus.rls_idx[k])) begin
                  dup_rls    = 1'b1;
                  rls_eff[k] = 1'b0;
               end
            end
         end
      end
      dbl_free = |(rls_mask & free_map_q);
   end

   always_comb begin
      err_d = err_q | dbl_free | dup_rls | (bus.alloc_vld & ~cnt_legal);
      if (bus.flush) begin
         free_map_d = RST_FREE_MAP;
         free_cnt_d = RstFreeCnt;
      end else begin
         free_map_d = (free_map_q & ~alloc_mask) | rls_mask;
         free_cnt_d = free_cnt_q - alloc_n + cnt_t'(popcnt4(rls_eff));
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         free_map_q <= RST_FREE_MAP;
         free_cnt_q <= RstFreeCnt;
         err_q      <= 1'b0;
      end else begin
         free_map_q <= free_map_d;
         free_cnt_q <= free_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.alloc_gnt = gnt;
   assign bus.free_cnt  = free_cnt_q;
   assign bus.full_n    = (32'(free_cnt_q) >= (32'(ALLOC_WAYS) + RSV_ENTRIES));
   assign bus.err       = err_q;

endmodule

// File: tb/tb_gnrl_alloc_64x4_ctrl.sv
// Directed bench for gnrl_alloc_64x4_ctrl using three instances with different parameters.
module tb_gnrl_alloc_64x4_ctrl;
   import gnrl_alloc_64x4_ctrl_pkg::*;

   localparam map_t MapB = 64'h0000_0100_0000_0020;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   gnrl_alloc_64x4_ctrl_if ia ();
   gnrl_alloc_64x4_ctrl_if ib ();
   gnrl_alloc_64x4_ctrl_if ic ();

   gnrl_alloc_64x4_ctrl #(.RST_FREE_MAP(64'hFFFF_FFFF_FFFF_FFFF), .RSV_ENTRIES(0)) dut_a (
      .i_clk (clk), .i_rst_n (rst_n), .bus (ia)
   );
   gnrl_alloc_64x4_ctrl #(.RST_FREE_MAP(MapB), .RSV_ENTRIES(0)) dut_b (
      .i_clk (clk), .i_rst_n (rst_n), .bus (ib)
   );
   gnrl_alloc_64x4_ctrl #(.RST_FREE_MAP(64'hFFFF_FFFF_FFFF_FFFF), .RSV_ENTRIES(2)) dut_c (
      .i_clk (clk), .i_rst_n (rst_n), .bus (ic)
   );

   task automatic idle();
      ia.alloc_vld = 1'b0; ia.alloc_cnt = '0; ia.rls_vld = '0; ia.rls_idx = '0; ia.flush = 1'b0;
      ib.alloc_vld = 1'b0; ib.alloc_cnt = '0; ib.rls_vld = '0; ib.rls_idx = '0; ib.flush = 1'b0;
      ic.alloc_vld = 1'b0; ic.alloc_cnt = '0; ic.rls_vld = '0; ic.rls_idx = '0; ic.flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      idle();
      ia.alloc_vld = 1'b1; ia.alloc_cnt = 3'd1;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (ia.free_cnt !== 7'd64) begin errors++;
         $display("FAIL rst_a_cnt got %0d exp 64", ia.free_cnt); end
      checks++; if (ia.err !== 1'b0) begin errors++;
         $display("FAIL rst_a_err got %0b exp 0", ia.err); end
      checks++; if (ia.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL rst_a_gnt got %0b exp 0", ia.alloc_gnt); end
      checks++; if (ia.alloc_idx !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++;
         $display("FAIL rst_a_idx got %h exp %h", ia.alloc_idx, {6'd3, 6'd2, 6'd1, 6'd0}); end
      checks++; if (ia.full_n !== 1'b1) begin errors++;
         $display("FAIL rst_a_full_n got %0b exp 1", ia.full_n); end
      checks++; if (ib.free_cnt !== 7'd2) begin errors++;
         $display("FAIL rst_b_cnt got %0d exp 2", ib.free_cnt); end
      checks++; if (ib.alloc_idx[0] !== 6'd5 || ib.alloc_idx[1] !== 6'd40) begin errors++;
         $display("FAIL rst_b_idx got %0d,%0d exp 5,40", ib.alloc_idx[0], ib.alloc_idx[1]); end
      checks++; if (ic.free_cnt !== 7'd64) begin errors++;
         $display("FAIL rst_c_cnt got %0d exp 64", ic.free_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      tick();
   endtask

   task automatic test_alloc4();
      ia.alloc_vld = 1'b1; ia.alloc_cnt = 3'd4;
      #1;
      checks++; if (ia.alloc_gnt !== 1'b1) begin errors++;
         $display("FAIL a4_gnt got %0b exp 1", ia.alloc_gnt); end
      checks++; if (ia.alloc_idx !== {6'd3, 6'd2, 6'd1, 6'd0}) begin errors++;
         $display("FAIL a4_idx got %h exp %h", ia.alloc_idx, {6'd3, 6'd2, 6'd1, 6'd0}); end
      tick(); idle(); #1;
      checks++; if (ia.free_cnt !== 7'd60) begin errors++;
         $display("FAIL a4_cnt got %0d exp 60", ia.free_cnt); end
      checks++; if (dut_a.free_map_q[3:0] !== 4'b0000) begin errors++;
         $display("FAIL a4_map got %b exp 0000", dut_a.free_map_q[3:0]); end
      checks++; if (ia.alloc_idx[0] !== 6'd4) begin errors++;
         $display("FAIL a4_next_idx got %0d exp 4", ia.alloc_idx[0]); end
   endtask

   task automatic test_scarce();
      ib.alloc_vld = 1'b1; ib.alloc_cnt = 3'd3;
      #1;
      checks++; if (ib.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL sc_gnt3 got %0b exp 0", ib.alloc_gnt); end
      checks++; if (ib.alloc_idx[2] !== 6'd0) begin errors++;
         $display("FAIL sc_idx2_forced got %0d exp 0", ib.alloc_idx[2]); end
      tick(); #1;
      checks++; if (ib.free_cnt !== 7'd2 || dut_b.free_map_q !== MapB) begin errors++;
         $display("FAIL sc_unchanged got cnt %0d map %h exp 2 %h", ib.free_cnt,
                  dut_b.free_map_q, MapB); end
      ib.alloc_cnt = 3'd2;
      #1;
      checks++; if (ib.alloc_gnt !== 1'b1) begin errors++;
         $display("FAIL sc_gnt2 got %0b exp 1", ib.alloc_gnt); end
      checks++; if (ib.alloc_idx[0] !== 6'd5 || ib.alloc_idx[1] !== 6'd40) begin errors++;
         $display("FAIL sc_idx got %0d,%0d exp 5,40", ib.alloc_idx[0], ib.alloc_idx[1]); end
      tick(); idle(); #1;
      checks++; if (ib.free_cnt !== 7'd0 || ib.full_n !== 1'b0) begin errors++;
         $display("FAIL sc_empty got cnt %0d full_n %0b exp 0 0", ib.free_cnt, ib.full_n); end
      checks++; if (ib.alloc_idx[0] !== 6'd0) begin errors++;
         $display("FAIL sc_empty_idx got %0d exp 0", ib.alloc_idx[0]); end
   endtask

   task automatic test_release_empty();
      ib.rls_vld = 4'b0011; ib.rls_idx[0] = 6'd7; ib.rls_idx[1] = 6'd9;
      ib.alloc_vld = 1'b1; ib.alloc_cnt = 3'd1;
      #1;
      checks++; if (ib.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL re_gnt got %0b exp 0", ib.alloc_gnt); end
      tick(); idle(); #1;
      checks++; if (ib.free_cnt !== 7'd2 || ib.err !== 1'b0) begin errors++;
         $display("FAIL re_cnt got cnt %0d err %0b exp 2 0", ib.free_cnt, ib.err); end
      ib.alloc_vld = 1'b1; ib.alloc_cnt = 3'd1;
      #1;
      checks++; if (ib.alloc_gnt !== 1'b1 || ib.alloc_idx[0] !== 6'd7) begin errors++;
         $display("FAIL re_alloc got gnt %0b idx %0d exp 1 7", ib.alloc_gnt, ib.alloc_idx[0]); end
      tick();
      ib.alloc_cnt = 3'd0;
      #1;
      checks++; if (ib.free_cnt !== 7'd1 || ib.alloc_gnt !== 1'b1) begin errors++;
         $display("FAIL re_cnt0 got cnt %0d gnt %0b exp 1 1", ib.free_cnt, ib.alloc_gnt); end
      tick(); idle(); #1;
      checks++; if (ib.free_cnt !== 7'd1) begin errors++;
         $display("FAIL re_cnt0_keep got %0d exp 1", ib.free_cnt); end
      ib.rls_vld = 4'b0011; ib.rls_idx[0] = 6'd20; ib.rls_idx[1] = 6'd20;
      tick(); idle(); #1;
      checks++; if (ib.err !== 1'b1 || ib.free_cnt !== 7'd2) begin errors++;
         $display("FAIL re_dup got err %0b cnt %0d exp 1 2", ib.err, ib.free_cnt); end
   endtask

   task automatic test_alloc_rls_same();
      ia.rls_vld = 4'b1111;
      ia.rls_idx[0] = 6'd0; ia.rls_idx[1] = 6'd1; ia.rls_idx[2] = 6'd2; ia.rls_idx[3] = 6'd3;
      tick(); idle(); #1;
      checks++; if (ia.free_cnt !== 7'd64 || ia.err !== 1'b0) begin errors++;
         $display("FAIL ar_refill got cnt %0d err %0b exp 64 0", ia.free_cnt, ia.err); end
      ia.alloc_vld = 1'b1; ia.alloc_cnt = 3'd2; ia.rls_vld = 4'b0001; ia.rls_idx[0] = 6'd0;
      #1;
      checks++; if (ia.alloc_gnt !== 1'b1 || ia.alloc_idx[1:0] !== {6'd1, 6'd0}) begin errors++;
         $display("FAIL ar_gnt got gnt %0b idx %h exp 1 %h", ia.alloc_gnt, ia.alloc_idx[1:0],
                  {6'd1, 6'd0}); end
      tick(); idle(); #1;
      checks++; if (ia.err !== 1'b1) begin errors++;
         $display("FAIL ar_err got %0b exp 1", ia.err); end
      checks++; if (dut_a.free_map_q[1:0] !== 2'b01 || ia.free_cnt !== 7'd63) begin errors++;
         $display("FAIL ar_state got map %b cnt %0d exp 01 63", dut_a.free_map_q[1:0],
                  ia.free_cnt); end
   endtask

   task automatic test_flush();
      ia.flush = 1'b1; ia.alloc_vld = 1'b1; ia.alloc_cnt = 3'd4; ia.rls_vld = 4'b1111;
      ia.rls_idx[0] = 6'd1; ia.rls_idx[1] = 6'd2; ia.rls_idx[2] = 6'd3; ia.rls_idx[3] = 6'd4;
      #1;
      checks++; if (ia.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL fl_gnt got %0b exp 0", ia.alloc_gnt); end
      tick(); idle(); #1;
      checks++; if (ia.free_cnt !== 7'd64 || dut_a.free_map_q !== 64'hFFFF_FFFF_FFFF_FFFF)
         begin errors++;
         $display("FAIL fl_state got cnt %0d map %h exp 64 all-ones", ia.free_cnt,
                  dut_a.free_map_q); end
      checks++; if (ia.err !== 1'b1) begin errors++;
         $display("FAIL fl_err_sticky got %0b exp 1", ia.err); end
   endtask

   task automatic test_reserve();
      int n_gnt;
      n_gnt = 0;
      checks++; if (ic.full_n !== 1'b1) begin errors++;
         $display("FAIL rv_full_n64 got %0b exp 1", ic.full_n); end
      for (int i = 0; i < 15; i++) begin
         ic.alloc_vld = 1'b1; ic.alloc_cnt = (i < 14) ? 3'd4 : 3'd3;
         #1;
         if (ic.alloc_gnt === 1'b1) n_gnt++;
         tick();
      end
      idle(); #1;
      checks++; if (n_gnt != 15) begin errors++;
         $display("FAIL rv_fill got %0d grants exp 15", n_gnt); end
      checks++; if (ic.free_cnt !== 7'd5 || ic.full_n !== 1'b0 || ic.err !== 1'b0) begin errors++;
         $display("FAIL rv_five got cnt %0d full_n %0b err %0b exp 5 0 0", ic.free_cnt,
                  ic.full_n, ic.err); end
      ic.alloc_vld = 1'b1; ic.alloc_cnt = 3'd3;
      #1;
      checks++; if (ic.alloc_gnt !== 1'b1) begin errors++;
         $display("FAIL rv_gnt3 got %0b exp 1", ic.alloc_gnt); end
      ic.alloc_cnt = 3'd4;
      #1;
      checks++; if (ic.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL rv_gnt4 got %0b exp 0", ic.alloc_gnt); end
      ic.alloc_cnt = 3'd5;
      #1;
      checks++; if (ic.alloc_gnt !== 1'b0) begin errors++;
         $display("FAIL rv_gnt5 got %0b exp 0", ic.alloc_gnt); end
      tick(); idle(); #1;
      checks++; if (ic.err !== 1'b1 || ic.free_cnt !== 7'd5) begin errors++;
         $display("FAIL rv_illegal got err %0b cnt %0d exp 1 5", ic.err, ic.free_cnt); end
      ic.alloc_vld = 1'b1; ic.alloc_cnt = 3'd1;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (ic.free_cnt !== 7'd64 || ic.err !== 1'b0 || ic.alloc_gnt !== 1'b0)
         begin errors++;
         $display("FAIL rv_async_rst got cnt %0d err %0b gnt %0b exp 64 0 0", ic.free_cnt,
                  ic.err, ic.alloc_gnt); end
      checks++; if (ia.err !== 1'b0 || ib.free_cnt !== 7'd2) begin errors++;
         $display("FAIL rv_async_rst_ab got a_err %0b b_cnt %0d exp 0 2", ia.err, ib.free_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
   endtask

   initial begin
      test_reset();
      test_alloc4();
      test_scarce();
      test_release_empty();
      test_alloc_rls_same();
      test_flush();
      test_reserve();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0d checks", checks);
      $fatal(1, "watchdog");
   end

endmodule
